// File: rtl/demorgan_pkg.sv
// demorgan_pkg: shared types and constants for the De Morgan sweep checker.
//   state_t   : sweep FSM encoding (IDLE, SWEEP, DONE)
//   MODE_NOR  : identity NOR(v)  == AND(~v)
//   MODE_NAND : identity NAND(v) == OR(~v)
package demorgan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic MODE_NOR  = 1'b0;
   localparam logic MODE_NAND = 1'b1;

endpackage

// File: rtl/demorgan_eval.sv
// demorgan_eval: combinational gate-level evaluation of both forms of a
// De Morgan identity over WIDTH inputs.
// Ports:
//   vec  (in,  WIDTH) : input vector
//   mode (in,  1)     : 0 = NOR / AND-of-complements, 1 = NAND / OR-of-complements
//   F1   (out, 1)     : gate form (NOR or NAND of vec)
//   F2   (out, 1)     : De Morgan form (AND or OR of ~vec)
module demorgan_eval #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] vec,
   input  logic             mode,
   output wire              F1,
   output wire              F2
);

   wire [WIDTH-1:0] vec_n;
   wire [WIDTH-1:0] or_c;
   wire [WIDTH-1:0] and_c;
   wire [WIDTH-1:0] or_n_c;
   wire [WIDTH-1:0] and_n_c;

   wire nor_v;
   wire nand_v;
   wire mode_n;
   wire f1_nor;
   wire f1_nand;
   wire f2_and;
   wire f2_or;

   buf u_or_0    (or_c[0],    vec[0]);
   buf u_and_0   (and_c[0],   vec[0]);
   buf u_or_n_0  (or_n_c[0],  vec_n[0]);
   buf u_and_n_0 (and_n_c[0], vec_n[0]);

   genvar i;
   for (i = 0; i < WIDTH; i++) begin : g_inv
      not u_not (vec_n[i], vec[i]);
   end

   // Ripple chains keep everything as 2-input primitives for any WIDTH.
   for (i = 1; i < WIDTH; i++) begin : g_chain
      or  u_or    (or_c[i],    or_c[i-1],    vec[i]);
      and u_and   (and_c[i],   and_c[i-1],   vec[i]);
      or  u_or_n  (or_n_c[i],  or_n_c[i-1],  vec_n[i]);
      and u_and_n (and_n_c[i], and_n_c[i-1], vec_n[i]);
   end

   not u_nor    (nor_v,  or_c[WIDTH-1]);
   not u_nand   (nand_v, and_c[WIDTH-1]);
   not u_mode_n (mode_n, mode);

   and u_f1_nor  (f1_nor,  nor_v,  mode_n);
   and u_f1_nand (f1_nand, nand_v, mode);
   or  u_f1      (F1, f1_nor, f1_nand);

   and u_f2_and (f2_and, and_n_c[WIDTH-1], mode_n);
   and u_f2_or  (f2_or,  or_n_c[WIDTH-1],  mode);
   or  u_f2     (F2, f2_and, f2_or);

endmodule

// File: rtl/demorgan_sweep_checker.sv
// demorgan_sweep_checker: sweeps every WIDTH-bit vector through both forms of
// a De Morgan identity and counts disagreements.
// Optional build macro: DEMORGAN_FAULT_INJECT_EN adds fault_en, which inverts
// F2 at vec==0 so the checker can be shown failing.
// Ports:
//   clk            (in)        : rising-edge clock
//   reset          (in)        : synchronous active-high reset
//   start          (in)        : launch a sweep (sampled in IDLE only)
//   mode           (in)        : identity select, latched at start
//   fault_en       (in)        : [macro only] break F2 at vec==0, latched at start
//   vec            (out,W)     : vector being evaluated
//   F1, F2         (out)       : registered results for the previous vector
//   busy           (out)       : high in SWEEP
//   done           (out)       : one-cycle pulse in DONE
//   pass           (out)       : last sweep had zero mismatches
//   mismatch_count (out,W+1)   : mismatches in current / last sweep
//   first_fail     (out,W)     : first mismatching vector
//
// state | meaning
// IDLE  | waiting for start
// SWEEP | one vector evaluated per cycle, 0 .. all-ones
// DONE  | done pulse; pass and mismatch_count final
module demorgan_sweep_checker
   import demorgan_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
`ifdef DEMORGAN_FAULT_INJECT_EN
   input  logic             fault_en,
`endif
   output logic [WIDTH-1:0] vec,
   output logic             F1,
   output logic             F2,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH:0]   mismatch_count,
   output logic [WIDTH-1:0] first_fail
);

   state_t state_q;
   state_t state_d;

   logic         mode_q;
   wire          f1_gate;
   wire          f2_gate;
   logic         f2_c;
   logic         mismatch;
   logic         vec_last;
   logic [WIDTH:0] mm_next;

   demorgan_eval #(.WIDTH(WIDTH)) u_eval (
      .vec  (vec),
      .mode (mode_q),
      .F1   (f1_gate),
      .F2   (f2_gate)
   );

`ifdef DEMORGAN_FAULT_INJECT_EN
   logic fault_q;
   assign f2_c = f2_gate ^ (fault_q & (vec == '0));
`else
   assign f2_c = f2_gate;
`endif

   assign mismatch = f1_gate ^ f2_c;
   assign vec_last = &vec;
   assign mm_next  = mismatch_count + {{WIDTH{1'b0}}, mismatch};

   assign busy = (state_q == SWEEP);
   assign done = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)    state_d = SWEEP;
         SWEEP:   if (vec_last) state_d = DONE;
         DONE:                  state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         vec            <= '0;
         F1             <= 1'b0;
         F2             <= 1'b0;
         pass           <= 1'b0;
         mismatch_count <= '0;
         first_fail     <= '0;
         mode_q         <= MODE_NOR;
`ifdef DEMORGAN_FAULT_INJECT_EN
         fault_q        <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  vec            <= '0;
                  mismatch_count <= '0;
                  first_fail     <= '0;
                  pass           <= 1'b0;
                  mode_q         <= mode;
`ifdef DEMORGAN_FAULT_INJECT_EN
                  fault_q        <= fault_en;
`endif
               end
            end
            SWEEP: begin
               F1 <= f1_gate;
               F2 <= f2_c;
               if (mismatch) begin
                  mismatch_count <= mm_next;
                  if (mismatch_count == '0) first_fail <= vec;
               end
               // pass is resolved on the last-vector edge using mm_next so
               // it is already valid while done is high, including a
               // mismatch on the final vector.
               if (vec_last) pass <= (mm_next == '0);
               else          vec  <= vec + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
module tb_demorgan_sweep_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic start3;
   logic start4;
   logic mode;
`ifdef DEMORGAN_FAULT_INJECT_EN
   logic fault_en;
`endif

   logic [2:0] vec3;
   logic       f1_3, f2_3, busy3, done3, pass3;
   logic [3:0] mm3;
   logic [2:0] ff3;

   logic [3:0] vec4;
   logic       f1_4, f2_4, busy4, done4, pass4;
   logic [4:0] mm4;
   logic [3:0] ff4;

   demorgan_sweep_checker #(.WIDTH(3)) u_dut3 (
      .clk            (clk),
      .reset          (reset),
      .start          (start3),
      .mode           (mode),
`ifdef DEMORGAN_FAULT_INJECT_EN
      .fault_en       (fault_en),
`endif
      .vec            (vec3),
      .F1             (f1_3),
      .F2             (f2_3),
      .busy           (busy3),
      .done           (done3),
      .pass           (pass3),
      .mismatch_count (mm3),
      .first_fail     (ff3)
   );

   demorgan_sweep_checker #(.WIDTH(4)) u_dut4 (
      .clk            (clk),
      .reset          (reset),
      .start          (start4),
      .mode           (mode),
`ifdef DEMORGAN_FAULT_INJECT_EN
      .fault_en       (fault_en),
`endif
      .vec            (vec4),
      .F1             (f1_4),
      .F2             (f2_4),
      .busy           (busy4),
      .done           (done4),
      .pass           (pass4),
      .mismatch_count (mm4),
      .first_fail     (ff4)
   );

   logic       sel4;
   logic [3:0] o_vec;
   logic       o_f1, o_f2, o_busy, o_done, o_pass;
   logic [4:0] o_mm;
   logic [3:0] o_ff;

   always_comb begin
      o_vec  = sel4 ? vec4  : {1'b0, vec3};
      o_f1   = sel4 ? f1_4  : f1_3;
      o_f2   = sel4 ? f2_4  : f2_3;
      o_busy = sel4 ? busy4 : busy3;
      o_done = sel4 ? done4 : done3;
      o_pass = sel4 ? pass4 : pass3;
      o_mm   = sel4 ? mm4   : {1'b0, mm3};
      o_ff   = sel4 ? ff4   : {1'b0, ff3};
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   logic [1:0] exp_q[$];

   // Truth-table model: NOR/AND(~v) is 1 only at v==0; NAND/OR(~v) is 1
   // everywhere but all-ones. Fault flips F2 at v==0.
   function automatic logic [1:0] model(input int v, input int vmax, input logic m, input logic f);
      logic f1;
      logic f2;
      f1 = m ? (v != vmax) : (v == 0);
      f2 = f1 ^ (f && (v == 0));
      return {f1, f2};
   endfunction

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_vec"},  {28'd0, o_vec}, 0);
      check_val({tag, "_f1"},   {31'd0, o_f1}, 0);
      check_val({tag, "_f2"},   {31'd0, o_f2}, 0);
      check_val({tag, "_busy"}, {31'd0, o_busy}, 0);
      check_val({tag, "_done"}, {31'd0, o_done}, 0);
      check_val({tag, "_pass"}, {31'd0, o_pass}, 0);
      check_val({tag, "_mm"},   {27'd0, o_mm}, 0);
      check_val({tag, "_ff"},   {28'd0, o_ff}, 0);
   endtask

   // Runs one sweep. poke_at: vector at which start is re-pulsed and mode
   // toggled (both must be ignored). reset_at: vector at which reset hits.
   task automatic run_sweep(input logic w4, input logic m, input logic f,
                            input int poke_at, input int reset_at);
      int         vmax;
      int         exp_mm;
      int         exp_ff;
      logic [1:0] e;
      logic [1:0] got;
      vmax   = w4 ? 15 : 7;
      exp_mm = 0;
      exp_ff = 0;
      sel4   = w4;
      mode   = m;
`ifdef DEMORGAN_FAULT_INJECT_EN
      fault_en = f;
`endif
      if (w4) start4 = 1'b1; else start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      start4 = 1'b0;
      for (int ev = 0; ev <= vmax; ev++) begin
         check_val("busy", {31'd0, o_busy}, 1);
         check_val("vec", {28'd0, o_vec}, ev);
         check_val("done_early", {31'd0, o_done}, 0);
         e = model(ev, vmax, m, f);
         exp_q.push_back(e);
         if (e[1] != e[0]) begin
            if (exp_mm == 0) exp_ff = ev;
            exp_mm++;
         end
         if (ev == poke_at) begin
            if (w4) start4 = 1'b1; else start3 = 1'b1;
            mode = ~m;
         end
         if (ev == reset_at) reset = 1'b1;
         @(posedge clk); #1;
         start3 = 1'b0;
         start4 = 1'b0;
         if (ev == reset_at) begin
            reset = 1'b0;
            check_reset_vals("midrst");
            exp_q.delete();
            @(posedge clk); #1;
            check_val("midrst_no_done", {31'd0, o_done}, 0);
            return;
         end
         if (exp_q.size() == 0) begin
            check_val("q_empty", 1, 0);
         end else begin
            got = {o_f1, o_f2};
            check_val("f1f2", {30'd0, got}, {30'd0, exp_q.pop_front()});
         end
      end
      check_val("done", {31'd0, o_done}, 1);
      check_val("busy_end", {31'd0, o_busy}, 0);
      check_val("pass", {31'd0, o_pass}, (exp_mm == 0) ? 1 : 0);
      check_val("mm", {27'd0, o_mm}, exp_mm);
      check_val("ff", {28'd0, o_ff}, exp_ff);
      check_val("vec_hold", {28'd0, o_vec}, vmax);
      @(posedge clk); #1;
      check_val("done_pulse", {31'd0, o_done}, 0);
      check_val("busy_idle", {31'd0, o_busy}, 0);
      check_val("pass_hold", {31'd0, o_pass}, (exp_mm == 0) ? 1 : 0);
   endtask

   initial begin
      reset  = 1'b1;
      start3 = 1'b0;
      start4 = 1'b0;
      mode   = 1'b0;
      sel4   = 1'b0;
`ifdef DEMORGAN_FAULT_INJECT_EN
      fault_en = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      check_reset_vals("rst3");
      sel4 = 1'b1;
      check_reset_vals("rst4");
      reset = 1'b0;

      run_sweep(1'b0, 1'b0, 1'b0, -1, -1);
      run_sweep(1'b0, 1'b1, 1'b0, -1, -1);
      run_sweep(1'b0, 1'b0, 1'b0, -1, 4);
      run_sweep(1'b0, 1'b0, 1'b0, -1, -1);
      run_sweep(1'b0, 1'b0, 1'b0, 3, -1);
      run_sweep(1'b1, 1'b0, 1'b0, 7, -1);
      run_sweep(1'b1, 1'b1, 1'b0, 5, -1);
`ifdef DEMORGAN_FAULT_INJECT_EN
      run_sweep(1'b0, 1'b0, 1'b1, -1, -1);
      run_sweep(1'b1, 1'b1, 1'b1, -1, -1);
      run_sweep(1'b0, 1'b0, 1'b0, -1, -1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
